// File: rtl/pattern_stim_sched_if.sv
// Handshake/bus bundle between a stimulus controller and the pattern scheduler.
interface pattern_stim_sched_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               abort;
  logic               load_en;
  logic [3:0]         load_addr;
  logic [DWELL_W+1:0] load_data;
  logic               match_in;
  logic               i2;
  logic               i1;
  logic [3:0]         step_idx;
  logic               busy;
  logic               done;
  logic               pass;
  logic               fail;

  modport master (
    output start, abort, load_en, load_addr, load_data, match_in,
    input  i2, i1, step_idx, busy, done, pass, fail
  );
  modport slave (
    input  start, abort, load_en, load_addr, load_data, match_in,
    output i2, i1, step_idx, busy, done, pass, fail
  );
endinterface

// File: rtl/pattern_stim_sched.sv
// Plays a loadable {i2,i1,dwell} table into a sequence detector, then grades
// the detector's match flag as pass (in the window) or fail (early or timeout).
module pattern_stim_sched #(
  parameter int NUM_STEPS = 11,
  parameter int DWELL_W   = 8,
  parameter int TIMEOUT   = 16
) (
  input logic clk,
  input logic reset,
  pattern_stim_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_MATCH, DONE} state_t;

  localparam int             EW      = DWELL_W + 2;
  localparam logic [4:0]     NS      = 5'(NUM_STEPS);
  localparam logic [3:0]     LAST    = 4'(NUM_STEPS - 1);
  localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);

  state_t              state;
  // Sixteen slots so the 4-bit index is always in range; only the first
  // NUM_STEPS are ever written, the rest stay at their reset value.
  logic [15:0][EW-1:0] tbl;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [7:0]          to_cnt;
  logic [EW-1:0]       cur, nxt;
  logic                idle_like;
  logic                i2_r, i1_r, busy_r, done_r, pass_r, fail_r;
  logic [3:0]          step_r;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign cur       = tbl[step_r];
  assign nxt       = tbl[step_r + 4'd1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tbl       <= '0;
      dwell_cnt <= '0;
      to_cnt    <= '0;
      i2_r      <= 1'b0;
      i1_r      <= 1'b0;
      step_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      if (bus.load_en && idle_like && ({1'b0, bus.load_addr} < NS))
        tbl[bus.load_addr] <= bus.load_data;

      if (bus.abort) begin
        state     <= IDLE;
        dwell_cnt <= '0;
        to_cnt    <= '0;
        i2_r      <= 1'b0;
        i1_r      <= 1'b0;
        step_r    <= '0;
        busy_r    <= 1'b0;
        done_r    <= 1'b0;
        pass_r    <= 1'b0;
        fail_r    <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state     <= DRIVE;
              step_r    <= '0;
              dwell_cnt <= '0;
              i2_r      <= tbl[0][EW-1];
              i1_r      <= tbl[0][EW-2];
              busy_r    <= 1'b1;
              done_r    <= 1'b0;
              pass_r    <= 1'b0;
              fail_r    <= 1'b0;
            end
          end
          DRIVE: begin
            // An early match wins over the step boundary, including the final cycle.
            if (bus.match_in) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              fail_r <= 1'b1;
              pass_r <= 1'b0;
              i2_r   <= 1'b0;
              i1_r   <= 1'b0;
            end else if (dwell_cnt == cur[DWELL_W-1:0]) begin
              dwell_cnt <= '0;
              if (step_r == LAST) begin
                state  <= WAIT_MATCH;
                to_cnt <= '0;
              end else begin
                step_r <= step_r + 4'd1;
                i2_r   <= nxt[EW-1];
                i1_r   <= nxt[EW-2];
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          WAIT_MATCH: begin
            if (bus.match_in || (to_cnt == TO_LAST)) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              pass_r <= bus.match_in;
              fail_r <= ~bus.match_in;
              i2_r   <= 1'b0;
              i1_r   <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.i2       = i2_r;
  assign bus.i1       = i1_r;
  assign bus.step_idx = step_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.fail     = fail_r;
endmodule
